// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one line-wide memory port between the I-cache and the D-cache.
// Only one line transaction runs at a time. The owner's command and data are
// forwarded to memory combinationally. The memory acknowledge goes back to the
// owner only. After each completion the arbiter spends one TURN cycle before it
// arbitrates again, so the finished requester has time to drop its request.
// A sticky watchdog flags a transaction that waits TIMEOUT cycles without
// mem_ready. The watchdog only flags the event; it never aborts the transfer.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> when both caches request at once, the
//                                    cache that did not own last wins.
//                       undefined -> fixed priority, D-cache over I-cache.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_read, i_addr           I-cache line read request (held until i_ready)
//   i_ready, i_rdata         I-cache completion strobe and line data
//   d_read, d_write, d_addr  D-cache read / write-back request
//   d_wdata                  D-cache write-back line
//   d_ready, d_rdata         D-cache completion strobe and line data
//   mem_read, mem_write      memory command
//   mem_addr, mem_wdata      memory line address / write data
//   mem_rdata, mem_ready     memory read data / single-cycle completion
//   timeout                  sticky watchdog flag, cleared only by rst
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              timeout
);

    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    // The flag is set on the same edge that moves the count onto TIMEOUT.
    localparam logic [WD_W-1:0] WD_ARM = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
    logic            i_req, d_req;
    logic            grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 1: the D-cache owned the most recently completed grant.
    logic            last_d_q, last_d_d;
`endif

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    assign timeout = timeout_q;

    // Winner selection; only consulted in IDLE.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant_d = !last_d_q;
        end else begin
            grant_d = d_req;
        end
`else
        grant_d = d_req;
`endif
    end

    // Next-state, watchdog and output decode.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default value first.
        // A branch that skips an assignment then still produces pure
        // combinational logic, and no latch is inferred.
        state_d   = state_q;
        wd_d      = '0;
        timeout_d = timeout_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ready   = 1'b0;
        i_rdata   = '0;
        d_ready   = 1'b0;
        d_rdata   = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d  = last_d_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = grant_d ? OWN_D : OWN_I;
                end
            end
            OWN_I: begin
                // The command follows the owner's live inputs. If the owner
                // drops its request too early, the command drops with it, but
                // ownership is kept until mem_ready arrives.
                mem_read = i_read;
                mem_addr = i_addr;
                if (mem_ready) begin
                    i_ready = 1'b1;
                    i_rdata = mem_rdata;
                    state_d = TURN;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            OWN_D: begin
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                if (mem_ready) begin
                    d_ready = 1'b1;
                    d_rdata = mem_rdata;
                    state_d = TURN;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b1;
`endif
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The count is zero outside OWN_x, so every grant starts from zero.
        // It saturates at TIMEOUT, so it cannot wrap during a long stall.
        if ((state_q == OWN_I || state_q == OWN_D) && !mem_ready) begin
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
            if (wd_q == WD_ARM) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments. All flops then
        // sample their _d values from the same pre-edge snapshot, so the
        // result does not depend on the order of the statements.
        if (rst) begin
            state_q   <= IDLE;
            wd_q      <= '0;
            timeout_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q  <= last_d_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. Each transaction is modelled at the
// transaction level. The bench picks the winner from the arbitration rule and
// the previous owner. It expects the command on the cycle after the request,
// a ready pulse together with mem_ready, and one quiet TURN cycle afterwards.
// The watchdog is expected to set after TIMEOUT waiting cycles and then stay set.
// Inputs are driven 1 time unit after posedge. Outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W  = 28;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 1023;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [LINE_W-1:0] i_rdata;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_ready;
    logic [LINE_W-1:0] d_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              timeout;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    bit last_was_d  = 1'b0;  // the reset value favours D on the next tie
    bit exp_timeout = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rand_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Arbitration rule: a single requester always wins. On a tie, the
    // D-cache wins in the fixed build. In the round-robin build, the cache
    // that did not own the previous grant wins.
    function automatic bit model_pick_d();
        bit want_i;
        bit want_d;
        want_i = i_read;
        want_d = d_read | d_write;
        if (want_i && want_d) begin
`ifdef ARB_ROUND_ROBIN_EN
            return !last_was_d;
`else
            return 1'b1;
`endif
        end
        return want_d;
    endfunction

    // Checks the outputs of an IDLE or TURN cycle: no command and no ready.
    task automatic check_quiet(input string tag);
        check({tag, ".mem_read"},  mem_read,  '0);
        check({tag, ".mem_write"}, mem_write, '0);
        check({tag, ".mem_addr"},  mem_addr,  '0);
        check({tag, ".mem_wdata"}, mem_wdata, '0);
        check({tag, ".i_ready"},   i_ready,   '0);
        check({tag, ".d_ready"},   d_ready,   '0);
        check({tag, ".i_rdata"},   i_rdata,   '0);
        check({tag, ".d_rdata"},   d_rdata,   '0);
        check({tag, ".timeout"},   timeout,   exp_timeout);
    endtask

    // Runs one transaction. Call it in an IDLE cycle, after the requests for
    // that cycle are driven. mem_ready comes 'delay' cycles after the first
    // command cycle. The owner drops its request at offset drop_at (-1 means
    // never), and always drops it in TURN. idle_pulse and turn_pulse send a
    // stray mem_ready in the IDLE and TURN cycles.
    task automatic txn(input string tag, input int delay, input int drop_at,
                       input bit idle_pulse, input bit turn_pulse);
        bit               own_d;
        bit               done;
        logic [LINE_W-1:0] rdv;
        own_d     = model_pick_d();
        mem_ready = idle_pulse;
        mem_rdata = rand_line();
        @(negedge clk);
        check_quiet({tag, ".idle"});
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k <= delay; k++) begin
            if (k == drop_at) begin
                if (own_d) begin
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end else begin
                    i_read = 1'b0;
                end
            end
            done      = (k == delay);
            mem_ready = done;
            rdv       = rand_line();
            mem_rdata = rdv;
            if (k >= TIMEOUT) exp_timeout = 1'b1;
            @(negedge clk);
            check({tag, ".mem_read"},  mem_read,  own_d ? d_read : i_read);
            check({tag, ".mem_write"}, mem_write, own_d ? d_write : 1'b0);
            check({tag, ".mem_addr"},  mem_addr,  own_d ? d_addr : i_addr);
            check({tag, ".mem_wdata"}, mem_wdata, own_d ? d_wdata : '0);
            check({tag, ".i_ready"},   i_ready,   !own_d && done);
            check({tag, ".d_ready"},   d_ready,   own_d && done);
            check({tag, ".i_rdata"},   i_rdata,   (!own_d && done) ? rdv : '0);
            check({tag, ".d_rdata"},   d_rdata,   (own_d && done) ? rdv : '0);
            check({tag, ".timeout"},   timeout,   exp_timeout);
            tick();
        end
        last_was_d = own_d;
        if (own_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        mem_ready = turn_pulse;
        mem_rdata = rand_line();
        @(negedge clk);
        check_quiet({tag, ".turn"});
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not reach its end");
        $fatal(1, "time limit");
    end

    initial begin
        rst       = 1'b1;
        i_read    = 1'b0;
        i_addr    = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ready = 1'b0;
        mem_rdata = rand_line();
        tick();
        tick();
        @(negedge clk);
        check_quiet("reset");
        tick();
        rst = 1'b0;

        // Lone I-cache read; memory answers 5 cycles after the command.
        i_read = 1'b1;
        i_addr = 28'h0000010;
        txn("i_lone", 5, -1, 1'b0, 1'b0);

        // D-cache write-back of the A5 pattern; stray pulses in IDLE and TURN.
        d_write = 1'b1;
        d_addr  = 28'h0ABCDE0;
        d_wdata = {16{8'hA5}};
        txn("d_wb", 2, -1, 1'b1, 1'b1);

        // Both requesting and held, four rounds; the winner re-requests each time.
        for (int r = 0; r < 4; r++) begin
            i_read = 1'b1;
            i_addr = 28'h0000100 + ADDR_W'(r);
            d_read = 1'b1;
            d_addr = 28'h0000200 + ADDR_W'(r);
            txn("both", 1, -1, 1'b0, 1'b0);
        end
        i_read = 1'b0;
        d_read = 1'b0;

        // Owner drops its request mid-transaction; ownership is kept.
        i_read = 1'b1;
        i_addr = 28'h0000333;
        txn("i_drop", 3, 1, 1'b0, 1'b0);

        // Random mix of requests, delays and stray pulses.
        for (int t = 0; t < 24; t++) begin
            bit want_i;
            bit want_d;
            want_i = rand_bit();
            want_d = rand_bit();
            if (!want_i && !want_d && !i_read && !d_read && !d_write) want_d = 1'b1;
            if (want_i && !i_read) begin
                i_read = 1'b1;
                i_addr = ADDR_W'($urandom);
            end
            if (want_d && !d_read && !d_write) begin
                if (rand_bit()) d_write = 1'b1;
                else            d_read  = 1'b1;
                d_addr  = ADDR_W'($urandom);
                d_wdata = rand_line();
            end
            txn("rand", int'($urandom_range(0, 6)), -1, rand_bit(), rand_bit());
        end
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;

        // Memory stalls past the watchdog limit; the flag stays set afterwards.
        i_read = 1'b1;
        i_addr = 28'h0FEDCBA;
        txn("stall", TIMEOUT + 5, -1, 1'b0, 1'b0);
        i_read = 1'b1;
        i_addr = 28'h0000044;
        txn("after_stall", 1, -1, 1'b0, 1'b0);

        // Reset two cycles into a D-cache write-back.
        d_write = 1'b1;
        d_addr  = 28'h0000777;
        d_wdata = rand_line();
        tick();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst.before.mem_write", mem_write, 1'b1);
        tick();
        rst         = 1'b0;
        d_write     = 1'b0;
        exp_timeout = 1'b0;
        last_was_d  = 1'b0;
        mem_ready   = 1'b1;
        @(negedge clk);
        check_quiet("rst.after");
        tick();
        mem_ready = 1'b0;
        i_read    = 1'b1;
        d_read    = 1'b1;
        i_addr    = 28'h0000050;
        d_addr    = 28'h0000060;
        txn("post_rst", 2, -1, 1'b0, 1'b0);
        i_read = 1'b0;
        d_read = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
